// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divide/remainder unit for RV32M in the EX stage.
// Stalls the front end while it works and pulses done_o for one cycle with the result.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             remSel_q, remSel_d;
  logic             quoNeg_q, quoNeg_d;
  logic             remNeg_q, remNeg_d;
  logic [4:0]       rdHold_q, rdHold_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rdOut_q, rdOut_d;

  logic             isSigned, rs1Neg, rs2Neg, divZero, overflow, special, accept;
  logic [WIDTH-1:0] rs1Abs, rs2Abs, specialRes, quoFix, remFix;
  logic [WIDTH:0]   shifted, trial;

  assign isSigned = ~op_i[0];
  assign rs1Neg   = isSigned & rs1_i[WIDTH-1];
  assign rs2Neg   = isSigned & rs2_i[WIDTH-1];
  assign rs1Abs   = rs1Neg ? (~rs1_i + ONE) : rs1_i;
  assign rs2Abs   = rs2Neg ? (~rs2_i + ONE) : rs2_i;
  assign divZero  = (rs2_i == '0);
  assign overflow = isSigned & (rs1_i == MIN_NEG) & (rs2_i == ALL_ONES);
  assign special  = divZero | overflow;
  assign accept   = (state_q == IDLE) & start_i & ~flush_i;

  // Divide-by-zero and signed overflow results are fixed by RV32M, so they skip the iteration.
  assign specialRes = op_i[1] ? (divZero ? rs1_i : '0)
                              : (divZero ? ALL_ONES : MIN_NEG);

  // The extra top bit of the trial difference is the borrow deciding each quotient bit.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_q};

  assign quoFix = quoNeg_q ? (~quo_q + ONE) : quo_q;
  assign remFix = remNeg_q ? (~rem_q + ONE) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    remSel_d = remSel_q;
    quoNeg_d = quoNeg_q;
    remNeg_d = remNeg_q;
    rdHold_d = rdHold_q;
    result_d = result_q;
    rdOut_d  = rdOut_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          remSel_d = op_i[1];
          rdHold_d = rd_i;
          quoNeg_d = rs1Neg ^ rs2Neg;
          remNeg_d = rs1Neg;
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = rs1Abs;
          div_d    = rs2Abs;
          if (special) begin
            result_d = specialRes;
            rdOut_d  = rd_i;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        result_d = remSel_q ? remFix : quoFix;
        rdOut_d  = rdHold_q;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush abandons the operation without touching the visible result.
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
      rdOut_d  = rdOut_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      remSel_q <= 1'b0;
      quoNeg_q <= 1'b0;
      remNeg_q <= 1'b0;
      rdHold_q <= '0;
      result_q <= '0;
      rdOut_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      remSel_q <= remSel_d;
      quoNeg_q <= quoNeg_d;
      remNeg_q <= remNeg_d;
      rdHold_q <= rdHold_d;
      result_q <= result_d;
      rdOut_q  <= rdOut_d;
    end
  end

  assign stall_o  = (accept & ~special) |
                    (((state_q == CALC) | (state_q == FIX)) & ~flush_i);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign rd_o     = rdOut_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: normal, signed, special-case,
// flush, ignored-start and asynchronous-reset scenarios with hand-computed results.
module tb_ex_div_unit;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  ex_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one operation at cycle T, then follows it to done_o and checks
  // latency, stall coverage, result, destination and hold behaviour.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expRes,
                               input int expLat);
    int cyc;
    int stallCnt;
    bit seen;
    stallCnt = 0;
    seen     = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    rd_i    = rd;
    #1;
    checkOutput({tag, ".stallT"}, {31'd0, stall_o}, (expLat > 1) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) stallCnt++;
    end
    if (!seen) cyc = 61;
    checkOutput({tag, ".latency"}, cyc, expLat);
    checkOutput({tag, ".stallCycles"}, stallCnt, expLat - 1);
    checkOutput({tag, ".stallAtDone"}, {31'd0, stall_o}, 32'd0);
    checkOutput({tag, ".result"}, result_o, expRes);
    checkOutput({tag, ".rd"}, {27'd0, rd_o}, {27'd0, rd});
    @(negedge clk);
    checkOutput({tag, ".doneDrop"}, {31'd0, done_o}, 32'd0);
    checkOutput({tag, ".resultHold"}, result_o, expRes);
  endtask

  initial begin
    int cyc;
    bit seen;
    reset   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    rs1_i   = '0;
    rs2_i   = '0;
    rd_i    = '0;
    flush_i = 1'b0;

    #3;
    checkOutput("rst.stall",  {31'd0, stall_o}, 32'd0);
    checkOutput("rst.busy",   {31'd0, busy_o},  32'd0);
    checkOutput("rst.done",   {31'd0, done_o},  32'd0);
    checkOutput("rst.result", result_o, 32'd0);
    checkOutput("rst.rd",     {27'd0, rd_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    applyStimulus("divu100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    applyStimulus("remu100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 34);
    applyStimulus("divM7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34);
    applyStimulus("remM7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34);
    applyStimulus("div7_M2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, 34);
    applyStimulus("rem7_M2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 34);
    applyStimulus("divuMax_16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd11, 32'h0FFF_FFFF, 34);
    applyStimulus("remuMax_16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd12, 32'd15, 34);
    applyStimulus("divMin_2",  OP_DIV,  32'h8000_0000, 32'd2, 5'd13, 32'hC000_0000, 34);

    applyStimulus("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
    applyStimulus("remOvf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
    applyStimulus("divu123_0", OP_DIVU, 32'd123, 32'd0, 5'd16, 32'hFFFF_FFFF, 1);
    applyStimulus("remu123_0", OP_REMU, 32'd123, 32'd0, 5'd17, 32'd123, 1);
    applyStimulus("divM5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFF, 1);
    applyStimulus("remM5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd19, 32'hFFFF_FFFB, 1);

    // start and flush together in IDLE: nothing accepted
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd50; rs2_i = 32'd5; rd_i = 5'd20;
    #1;
    checkOutput("flushIdle.stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flushIdle.busy", {31'd0, busy_o}, 32'd0);

    // flush at T+10 of DIVU 1000/3
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd21;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    seen = 1'b0;
    for (cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    checkOutput("flushCalc.stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flushCalc.busy", {31'd0, busy_o}, 32'd0);
    checkOutput("flushCalc.noDone", {31'd0, done_o | seen}, 32'd0);
    checkOutput("flushCalc.resultKept", result_o, 32'hFFFF_FFFB);
    applyStimulus("divu9_3", OP_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, 34);

    // start_i held high during CALC with other operands must be ignored
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd5;
    @(posedge clk);
    #1;
    op_i = OP_REMU; rs1_i = 32'd55; rs2_i = 32'd4; rd_i = 5'd9;
    seen = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    if (!seen) cyc = 61;
    checkOutput("heldStart.latency", cyc, 34);
    checkOutput("heldStart.result", result_o, 32'd14);
    checkOutput("heldStart.rd", {27'd0, rd_o}, 32'd5);

    // asynchronous reset at T+5
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd23;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncRst.stall",  {31'd0, stall_o}, 32'd0);
    checkOutput("asyncRst.busy",   {31'd0, busy_o},  32'd0);
    checkOutput("asyncRst.done",   {31'd0, done_o},  32'd0);
    checkOutput("asyncRst.result", result_o, 32'd0);
    checkOutput("asyncRst.rd",     {27'd0, rd_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("postRst", OP_DIVU, 32'd9, 32'd3, 5'd24, 32'd3, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divide/remainder unit in the EX stage. It consumes the operands and control that the ID/EX pipeline register delivers.
- Runs radix-2 restoring division, one quotient bit per cycle.
- While it works, it drives a stall back to the ID/EX register and the front end.
- Presents the result and destination register for one cycle so EX/MEM captures it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two ≥ 8.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start_i  input  1  EX holds a valid DIV/DIVU/REM/REMU this cycle
- op_i  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_i  input  WIDTH  dividend (RD1_e after forwarding)
- rs2_i  input  WIDTH  divisor (RD2_e after forwarding)
- rd_i  input  5  destination register index
- flush_i  input  1  kill the in-flight operation (branch mispredict/trap)
- stall_o  output  1  hold ID/EX and upstream stages
- busy_o  output  1  FSM not in IDLE
- done_o  output  1  one-cycle pulse: result_o/rd_o valid
- result_o  output  WIDTH  quotient or remainder
- rd_o  output  5  latched destination index

Behaviour:
- Reset (reset=0, asynchronous) clears all state and returns the FSM to IDLE. Output reset values:
  - stall_o=0, busy_o=0, done_o=0, result_o=0, rd_o=0.
  - Counter, remainder, quotient and divisor registers are cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- Operand acceptance:
  - Accepted only in IDLE, when start_i=1 and flush_i=0, at the clock edge ending cycle T.
  - On acceptance, latch op_i and rd_i.
  - For signed ops (DIV/REM), latch |rs1| and |rs2| plus the sign flags: quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - For unsigned ops, latch operands unchanged and both sign flags = 0.
- Special cases are decided at acceptance; the FSM goes IDLE→DONE, so done_o=1 in T+1:
  - Divide by zero (rs2=0): quotient = all ones, remainder = rs1.
  - Signed overflow (DIV/REM, rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
- Normal path:
  - IDLE→CALC. CALC runs exactly WIDTH cycles (T+1..T+WIDTH), counter 0..WIDTH-1.
  - Each CALC cycle: shift {rem,quo} left by 1, trial-subtract the divisor from rem; if non-negative, keep the difference and set quo[0]=1.
  - When counter = WIDTH-1, CALC→FIX.
  - FIX (T+WIDTH+1): negate quotient/remainder per the latched sign flags, select the quotient or remainder per op, register into result_o.
  - FIX→DONE. DONE (T+WIDTH+2) asserts done_o=1 with result_o/rd_o valid, then DONE→IDLE.
  - Total latency is WIDTH+2 cycles (34 at default).
- result_o and rd_o hold their value after DONE until the next DONE overwrites them.
- stall_o (combinational) = (IDLE & start_i & ~flush_i) | CALC | FIX.
  - stall_o is 0 in DONE, so the pipeline advances exactly as done_o pulses.
  - stall_o is 0 on the acceptance cycle of a special case.
- busy_o = (state ≠ IDLE).
- start_i outside IDLE is ignored; it must not restart or corrupt the operation.
- flush_i=1 in any state:
  - Next state is IDLE with no done_o pulse; stall_o drops in the same cycle.
  - A flush in DONE still lets that cycle's done_o=1 stand. The flush applies after that cycle.
  - start_i and flush_i together in IDLE: flush wins, nothing is accepted.
- Reset asserted mid-CALC aborts immediately. After release, the unit is in IDLE and accepts a new start.
- Sign negation uses two's complement in WIDTH bits. Intermediate remainder is WIDTH+1 bits to hold the subtract borrow.

Test Plan:
- DIVU 100/7, rd=5, start at T → stall_o high T..T+33, done_o=1 only at T+34, result_o=14, rd_o=5; REMU same operands → result_o=2.
- DIV −7/2 → 0xFFFF_FFFD (−3); REM −7/2 → 0xFFFF_FFFF (−1); DIV 7/−2 → 0xFFFF_FFFD; REM 7/−2 → 1.
- DIV 0x8000_0000/0xFFFF_FFFF → done_o at T+1, result 0x8000_0000, stall_o never high; REM same → 0.
- DIVU 123/0 → done_o at T+1, result 0xFFFF_FFFF; REMU 123/0 → 123; DIV −5/0 → 0xFFFF_FFFF.
- Start DIVU 1000/3, flush_i at T+10 → busy_o=0 at T+11, no done_o pulse; new DIVU 9/3 at T+12 → done_o at T+46, result 3.
- start_i held high during CALC with different operands → first result unaffected; reset pulled low at T+5 → all outputs 0 asynchronously; after release, IDLE and a fresh op completes.
